// File: rtl/pacman_pkg.sv
// Shared map geometry, direction encoding and tile-step helper for the
// player and ghost movers.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    localparam int unsigned MAP_W = 50;
    localparam int unsigned MAP_H = 32;

    typedef logic [5:0] tile_x_t;
    typedef logic [4:0] tile_y_t;

    typedef struct packed {
        tile_x_t x;
        tile_y_t y;
    } tile_pos_t;

    // Neighbouring tile with tunnel wrap on both axes; w/h default to the
    // shared map size but can follow a module's own geometry parameters.
    function automatic tile_pos_t next_tile(
        input tile_x_t     x,
        input tile_y_t     y,
        input dir_e        dir,
        input int unsigned w = MAP_W,
        input int unsigned h = MAP_H
    );
        tile_pos_t p;
        tile_x_t   x_max;
        tile_y_t   y_max;
        x_max = tile_x_t'(w - 1);
        y_max = tile_y_t'(h - 1);
        p.x = x;
        p.y = y;
        case (dir)
            UP:      p.y = (y == '0)    ? y_max : y - tile_y_t'(1);
            DOWN:    p.y = (y == y_max) ? '0    : y + tile_y_t'(1);
            LEFT:    p.x = (x == '0)    ? x_max : x - tile_x_t'(1);
            default: p.x = (x == x_max) ? '0    : x + tile_x_t'(1);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pacman_mover.sv
// Player tile-movement sequencer: per game tick, probe the map ahead in the
// requested direction, fall back to the current one, commit and clear.
module pacman_mover #(
    parameter int unsigned MAP_W    = pacman_pkg::MAP_W,
    parameter int unsigned MAP_H    = pacman_pkg::MAP_H,
    parameter int unsigned START_X  = 1,
    parameter int unsigned START_Y  = 1,
    parameter bit          CLEAR_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_dir_valid,
    input  logic [1:0] i_dir,
    output logic       o_map_en,
    output logic       o_map_write,
    output logic [5:0] o_tile_x,
    output logic [4:0] o_tile_y,
    input  logic       i_tile_value,
    output logic [5:0] o_pos_x,
    output logic [4:0] o_pos_y,
    output logic [1:0] o_dir,
    output logic       o_moving,
    output logic       o_busy,
    output logic       o_step_done,
    output logic       o_overrun
);
    import pacman_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        CHK_A,
        REQ_B,
        CHK_B,
        DONE
    } state_e;

    state_e    state, state_next;
    tile_x_t   pos_x, addr_x;
    tile_y_t   pos_y, addr_y;
    dir_e      dir, cand, pend_dir, req_dir, cand_in;
    logic      pend_valid, moving;
    tile_pos_t addr_a, addr_b;
    logic      load_a, load_b, commit, block, map_en, map_write, step_done;

    assign req_dir = dir_e'(i_dir);
    assign cand_in = i_dir_valid ? req_dir : (pend_valid ? pend_dir : dir);
    assign addr_a  = next_tile(pos_x, pos_y, cand_in, MAP_W, MAP_H);
    assign addr_b  = next_tile(pos_x, pos_y, dir, MAP_W, MAP_H);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        commit     = 1'b0;
        block      = 1'b0;
        map_en     = 1'b0;
        map_write  = 1'b0;
        step_done  = 1'b0;
        case (state)
            IDLE: begin
                if (i_tick) begin
                    load_a     = 1'b1;
                    state_next = REQ_A;
                end
            end
            REQ_A: begin
                map_en     = 1'b1;
                state_next = CHK_A;
            end
            CHK_A: begin
                if (!i_tile_value) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end else if (cand != dir) begin
                    load_b     = 1'b1;
                    state_next = REQ_B;
                end else begin
                    block      = 1'b1;
                    state_next = DONE;
                end
            end
            REQ_B: begin
                map_en     = 1'b1;
                state_next = CHK_B;
            end
            CHK_B: begin
                commit     = !i_tile_value;
                block      = i_tile_value;
                state_next = DONE;
            end
            DONE: begin
                step_done  = 1'b1;
                // moving was set at commit, so it marks a freshly entered tile
                map_en     = moving && CLEAR_EN;
                map_write  = moving && CLEAR_EN;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The probe address of a successful check is the new position, so the
    // address register also serves the clear write in DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_x  <= tile_x_t'(START_X);
            pos_y  <= tile_y_t'(START_Y);
            dir    <= RIGHT;
            cand   <= RIGHT;
            moving <= 1'b0;
            addr_x <= '0;
            addr_y <= '0;
        end else begin
            if (load_a) begin
                cand   <= cand_in;
                addr_x <= addr_a.x;
                addr_y <= addr_a.y;
            end
            if (load_b) begin
                addr_x <= addr_b.x;
                addr_y <= addr_b.y;
            end
            if (commit) begin
                pos_x  <= addr_x;
                pos_y  <= addr_y;
                moving <= 1'b1;
                if (state == CHK_A) dir <= cand;
            end
            if (block) moving <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_valid <= 1'b0;
            pend_dir   <= UP;
        end else if (i_dir_valid) begin
            pend_valid <= 1'b1;
            pend_dir   <= req_dir;
        end else if (commit && state == CHK_A && pend_dir == cand) begin
            pend_valid <= 1'b0;
        end
    end

    assign o_map_en    = map_en;
    assign o_map_write = map_write;
    assign o_tile_x    = addr_x;
    assign o_tile_y    = addr_y;
    assign o_pos_x     = pos_x;
    assign o_pos_y     = pos_y;
    assign o_dir       = dir;
    assign o_moving    = moving;
    assign o_busy      = (state != IDLE);
    assign o_step_done = step_done;
    assign o_overrun   = i_tick && (state != IDLE);

endmodule

// File: tb/tb_pacman_mover.sv
// Scoreboard bench for pacman_mover: a tile-level reference model predicts
// map accesses, step results and overrun pulses; a monitor consumes them.
`timescale 1ns/1ps
module tb_pacman_mover;
    localparam int W = 50;
    localparam int H = 32;

    logic       clk = 1'b0;
    logic       rst, tick, dir_valid;
    logic [1:0] dir_in;
    logic       map_en, map_write, tile_value;
    logic [5:0] tile_x, pos_x;
    logic [4:0] tile_y, pos_y;
    logic [1:0] dir;
    logic       moving, busy, step_done, overrun;

    always #5 clk = ~clk;

    pacman_mover #(
        .MAP_W(50), .MAP_H(32), .START_X(1), .START_Y(1), .CLEAR_EN(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_dir_valid(dir_valid),
        .i_dir(dir_in), .o_map_en(map_en), .o_map_write(map_write),
        .o_tile_x(tile_x), .o_tile_y(tile_y), .i_tile_value(tile_value),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_dir(dir), .o_moving(moving),
        .o_busy(busy), .o_step_done(step_done), .o_overrun(overrun)
    );

    typedef struct { int cyc; int x; int y; int wr; } acc_t;
    typedef struct { int cyc; int x; int y; int d; int mv; } step_t;

    acc_t  acc_q[$];
    step_t step_q[$];
    int    ovr_q[$];
    bit    wall [W][H];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    mx, my, md, pd;
    bit    pv;

    always @(posedge clk) cyc <= cyc + 1;

    // Map RAM model: one-cycle read latency, garbage when not reading
    always @(posedge clk)
        tile_value <= (map_en && !map_write && tile_x < W && tile_y < H)
                      ? wall[tile_x][tile_y] : 1'($urandom);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void nxt(input int x, input int y, input int d,
                                output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            0:       ny = (y + H - 1) % H;
            1:       ny = (y + 1) % H;
            2:       nx = (x + W - 1) % W;
            default: nx = (x + 1) % W;
        endcase
    endfunction

    // Reference model of one step started by a tick seen in cycle t
    task automatic predict(input int t);
        int cand, ax, ay, bx, by;
        cand = pv ? pd : md;
        nxt(mx, my, cand, ax, ay);
        acc_q.push_back('{t + 1, ax, ay, 0});
        if (!wall[ax][ay]) begin
            mx = ax; my = ay; md = cand; pv = 0;
            acc_q.push_back('{t + 3, ax, ay, 1});
            step_q.push_back('{t + 3, mx, my, md, 1});
        end else if (cand != md) begin
            nxt(mx, my, md, bx, by);
            acc_q.push_back('{t + 3, bx, by, 0});
            if (!wall[bx][by]) begin
                mx = bx; my = by;
                acc_q.push_back('{t + 5, bx, by, 1});
                step_q.push_back('{t + 5, mx, my, md, 1});
            end else begin
                step_q.push_back('{t + 5, mx, my, md, 0});
            end
        end else begin
            step_q.push_back('{t + 3, mx, my, md, 0});
        end
    endtask

    always @(negedge clk) begin
        acc_t  a;
        step_t s;
        int    o;
        if (map_en) begin
            if (acc_q.size() == 0) check("unexpected map access", 1, 0);
            else begin
                a = acc_q.pop_front();
                check("access cycle", cyc, a.cyc);
                check("access x", int'(tile_x), a.x);
                check("access y", int'(tile_y), a.y);
                check("access write", int'(map_write), a.wr);
            end
        end
        if (step_done) begin
            if (step_q.size() == 0) check("unexpected step_done", 1, 0);
            else begin
                s = step_q.pop_front();
                check("step cycle", cyc, s.cyc);
                check("pos x", int'(pos_x), s.x);
                check("pos y", int'(pos_y), s.y);
                check("dir", int'(dir), s.d);
                check("moving", int'(moving), s.mv);
            end
        end
        if (overrun) begin
            if (ovr_q.size() == 0) check("unexpected overrun", 1, 0);
            else begin
                o = ovr_q.pop_front();
                check("overrun cycle", cyc, o);
            end
        end
    end

    task automatic flush();
        acc_q.delete();
        step_q.delete();
        ovr_q.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((acc_q.size() != 0 || step_q.size() != 0 || ovr_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            check("step timeout", 1, 0);
            flush();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_step(input bit req, input int d, input bit rnd);
        int t, nx, ny;
        if (rnd)
            for (int k = 0; k < 4; k++) begin
                nxt(mx, my, k, nx, ny);
                wall[nx][ny] = ($urandom % 100) < 35;
            end
        @(posedge clk); #1;
        if (req) begin
            dir_valid = 1'b1;
            dir_in    = 2'(d);
            pv        = 1;
            pd        = d;
        end
        tick = 1'b1;
        t = cyc;
        predict(t);
        @(posedge clk); #1;
        tick      = 1'b0;
        dir_valid = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs();
        check("rst pos_x", int'(pos_x), 1);
        check("rst pos_y", int'(pos_y), 1);
        check("rst dir", int'(dir), 3);
        check("rst moving", int'(moving), 0);
        check("rst busy", int'(busy), 0);
        check("rst step_done", int'(step_done), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst map_en", int'(map_en), 0);
        check("rst map_write", int'(map_write), 0);
        check("rst tile_x", int'(tile_x), 0);
        check("rst tile_y", int'(tile_y), 0);
    endtask

    task automatic clear_map();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                wall[x][y] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst = 1'b1; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
        clear_map();
        mx = 1; my = 1; md = 3; pv = 0; pd = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // open corridor and both tunnel axes
        do_step(0, 0, 0);
        do_step(1, 2, 0);
        do_step(0, 0, 0);
        do_step(0, 0, 0);
        do_step(1, 3, 0);
        do_step(1, 0, 0);
        do_step(0, 0, 0);
        do_step(1, 1, 0);

        // requested up blocked, fall back to down; pending up retried next tick
        wall[0][31] = 1;
        do_step(1, 0, 0);
        wall[0][31] = 0;
        do_step(0, 0, 0);
        // now at (0,0) heading up: straight into a wall, then both blocked
        wall[0][31] = 1;
        do_step(0, 0, 0);
        wall[1][0] = 1;
        do_step(1, 3, 0);
        clear_map();

        // second tick two cycles later is dropped with an overrun pulse
        @(posedge clk); #1;
        tick = 1'b1; t = cyc; predict(t);
        @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1; tick = 1'b1; ovr_q.push_back(cyc);
        @(posedge clk); #1; tick = 1'b0;
        drain();

        // asynchronous reset during CHK_A
        @(posedge clk); #1;
        tick = 1'b1; t = cyc; predict(t);
        @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        flush();
        mx = 1; my = 1; md = 3; pv = 0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 80; i++)
            do_step(($urandom % 2) == 1, int'($urandom % 4), 1);

        check("leftover expectations", acc_q.size() + step_q.size() + ovr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
